// File: rtl/ram_access_unit.sv
// Load/store bridge between the CPU memory stage and a byte-enable word RAM.
// Builds lane enables and replicated store data; aligns and extends loads.
module ram_access_unit #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_error,
  output logic [3:0]               ram_we,
  output logic [ADDRESS_WIDTH-3:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_data,
  input  logic [DATA_WIDTH-1:0]    ram_q
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic                  accept;
  logic                  req_err;
  logic [3:0]            lane_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  ext;

  assign accept = req_valid && rst_n && (state_q == IDLE);

  assign req_err = (req_size == 2'd3)
                || (req_size == 2'd1 && req_addr[0])
                || (req_size == 2'd2 && req_addr[1:0] != 2'd0);

  always_comb begin
    lane_mask = 4'b1111;
    ram_data  = req_wdata;
    unique case (req_size)
      2'd0: begin
        lane_mask = 4'b0001 << req_addr[1:0];
        ram_data  = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lane_mask = 4'b0011 << req_addr[1:0];
        ram_data  = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err || req_write) state_d = RESP;
          else                      state_d = READ;
        end
      end
      READ:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) && rst_n;
    rsp_valid = (state_q == RESP);
    ram_we    = 4'b0000;
    if (accept && req_write && !req_err)
      ram_we = lane_mask;
    if (state_q == IDLE)
      ram_addr = req_addr[ADDRESS_WIDTH-1:2];
    else
      ram_addr = addr_q[ADDRESS_WIDTH-1:2];
  end

  // Load data arrives from the RAM's output register while in READ.
  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    shifted = ram_q >> {addr_q[1:0], 3'b000};
    ext     = 1'b0;
    if (accept) begin
      addr_d  = req_addr;
      size_d  = req_size;
      uns_d   = req_unsigned;
      err_d   = req_err;
      rdata_d = '0;
    end else if (state_q == READ) begin
      unique case (size_q)
        2'd0: begin
          ext     = !uns_q && shifted[7];
          rdata_d = {{24{ext}}, shifted[7:0]};
        end
        2'd1: begin
          ext     = !uns_q && shifted[15];
          rdata_d = {{16{ext}}, shifted[15:0]};
        end
        default: rdata_d = ram_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

endmodule

// File: doc/ram_access_unit.md
Name: ram_access_unit

Overview:
- Initiator-side bridge between the CPU load/store stage and the single-port byte-enable word RAM.
- Accepts byte-addressed load/store requests of byte, half or word size over a valid/ready handshake.
- Generates word address, byte-lane write enables and lane-replicated write data for the RAM.
- Aligns and sign/zero-extends read data, and returns a response with an error flag for misaligned or unsupported accesses.

Parameters:
- ADDRESS_WIDTH, 14, byte-address width; RAM word address is ADDRESS_WIDTH-2 bits.
- DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock; everything on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved.
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  32  aligned, extended load data; 0 for stores and errors.
- rsp_error  out  1  misaligned or reserved-size access.
- ram_we  out  4  byte-lane write enables to RAM.
- ram_addr  out  ADDRESS_WIDTH-2  RAM word address (byte address bits [ADDRESS_WIDTH-1:2]).
- ram_data  out  32  RAM write data.
- ram_q  in  32  RAM read data, registered in RAM, valid one cycle after address.

Behaviour:
- FSM states: IDLE, READ, RESP. Reset (async, rst_n low) -> IDLE, rsp_valid=0, rsp_error=0, rsp_rdata=0, address/size/sign registers 0.
- req_ready = (state==IDLE) && rst_n. Accept = req_valid && req_ready.
- In IDLE, ram_addr = req_addr[ADDRESS_WIDTH-1:2], combinationally. In other states, ram_addr = registered address of the accepted request.
- Error = (size==3) || (size==1 && addr[0]) || (size==2 && addr[1:0]!=0).
- ram_we:
  - Byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
  - Driven only when Accept && req_write && !Error; otherwise 4'b0000.
  - Forced 0 while rst_n low. The write completes at the accepting edge.
- ram_data: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
- Accepted store, no error: -> RESP. rsp_valid=1, rsp_error=0, rsp_rdata=0 on the next cycle (latency 1).
- Accepted load, no error: -> READ; ram_q is valid in READ.
  - On the READ edge: shift = ram_q >> (8*addr[1:0]).
  - Byte: rsp_rdata = {24 ext, shift[7:0]}. Half: {16 ext, shift[15:0]}. Word: ram_q.
  - ext = 0 if unsigned, else the MSB of the selected field.
  - -> RESP. rsp_valid is high 2 cycles after accept.
- Accepted request with Error: no RAM write. -> RESP with rsp_error=1, rsp_rdata=0, latency 1. Loads also skip READ.
- RESP: outputs held stable until rsp_ready. On rsp_valid && rsp_ready -> IDLE, rsp_valid=0. A new request is accepted no earlier than the following cycle (no same-cycle overlap).
- req_* inputs are ignored outside IDLE. The address is captured at accept; later changes have no effect.
- Reset mid-operation: a pending response is dropped and no spurious ram_we is produced. A store already accepted before reset has completed.

Test Plan:
- Word store then load: store addr 0x010 data 0xDEADBEEF -> ram_we=1111, ram_addr=4, response after 1 cycle. Load word 0x010 -> rsp_rdata=0xDEADBEEF, 2 cycles after accept, rsp_error=0.
- Byte/half lanes: store byte 0xA5 at 0x013 -> ram_we=1000, ram_data=0xA5A5A5A5. Store half 0x1234 at 0x016 -> ram_we=1100, ram_data=0x12341234.
- Extension: with word 0x80F17F00 at 0x020:
  - LB 0x022 signed -> 0xFFFFFFF1; LBU 0x022 -> 0x000000F1.
  - LH 0x022 signed -> 0xFFFF80F1; LH 0x020 -> 0x00007F00.
- Errors: SW at 0x011, SH at 0x023, LW size=3 at 0x020 -> each rsp_error=1, rsp_rdata=0, ram_we stays 0000, memory unchanged on readback.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load -> rsp_valid/rsp_rdata stable, req_ready=0. A second req_valid is not accepted until the cycle after the handshake.
- Reset mid-load: assert rst_n=0 in READ -> rsp_valid=0, req_ready=0, ram_we=0000 immediately. After release -> IDLE, req_ready=1, and the next load returns correct data.
